// File: rtl/flag_cond_pkg.sv
// Shared definitions for the flag register / branch-condition path.
package flag_cond_pkg;

    // Bit positions inside a {C,S,V,Z} flag vector
    localparam int C_B = 3;
    localparam int S_B = 2;
    localparam int V_B = 1;
    localparam int Z_B = 0;

    // Condition codes carried by br_cond
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Branch resolution FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } br_state_t;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Pure combinational condition evaluator; also usable by the decode stage.
module cond_eval
    import flag_cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic c, s, v, z;
    assign c = flags[C_B];
    assign s = flags[S_B];
    assign v = flags[V_B];
    assign z = flags[Z_B];

    // Decode the condition code against the supplied flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = s;
            COND_PL: taken = ~s;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = ~(s ^ v);
            COND_LT: taken = s ^ v;
            COND_GT: taken = ~z & ~(s ^ v);
            COND_LE: taken = z | (s ^ v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register, in-flight flag-setter tracking, interrupt
// shadow, and in-order resolution of conditional branches.
module flag_cond_unit
    import flag_cond_pkg::*;
#(
    parameter int         PEND_W      = 3,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       fs_issue,
    input  logic       fs_wr,
    input  logic [3:0] fs_mask,
    input  logic       c_in,
    input  logic       s_in,
    input  logic       v_in,
    input  logic       z_in,
    input  logic       br_valid,
    output logic       br_ready,
    input  logic [3:0] br_cond,
    output logic       br_resp_valid,
    input  logic       br_resp_ready,
    output logic       br_taken,
    input  logic       sv_save,
    input  logic       sv_restore,
    output logic [3:0] flags_q,
    output logic       pend_full,
    output logic       ovf_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [3:0] flags_r, shadow_r;
    logic [3:0] new_flags, wen, wr_flags, nxt_flags;

    logic [PEND_W-1:0] pend, wait_cnt, wait_nxt, wr_dec;
    logic              inc, dec;

    br_state_t  state, state_nxt;
    logic [3:0] cond_q, cond_nxt, eval_cond;
    logic       taken_q, taken_nxt, eval_taken;

    // ---------------- flags and shadow ----------------
    assign new_flags = {c_in, s_in, v_in, z_in};
    assign wen       = fs_mask & {4{fs_wr}};
    assign wr_flags  = (wen & new_flags) | (~wen & flags_r);
    // Restore wins over any same-cycle EX write
    assign nxt_flags = sv_restore ? shadow_r : wr_flags;

    // Flag register and shadow; save captures the unrestored value so
    // save+restore together swaps the two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r  <= RESET_FLAGS;
            shadow_r <= RESET_FLAGS;
        end else begin
            flags_r <= nxt_flags;
            if (sv_save) shadow_r <= wr_flags;
        end
    end

    assign flags_q = flags_r;

    // ---------------- pending counter ----------------
    assign pend_full = (pend == PEND_MAX);
    // Issue while full only counts when a write frees a slot in the same cycle
    assign inc = fs_issue & (~pend_full | fs_wr);
    // A stray write with nothing pending must not wrap the counter
    assign dec = fs_wr & (pend != '0);

    // In-flight flag-setter count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pend <= '0;
        else if (flush)       pend <= '0;
        else if (inc && !dec) pend <= pend + PEND_ONE;
        else if (dec && !inc) pend <= pend - PEND_ONE;
    end

    // Sticky overflow; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     ovf_err <= 1'b0;
        else if (fs_issue && pend_full) ovf_err <= 1'b1;
    end

    // ---------------- branch FSM ----------------
    // In IDLE the live request is evaluated; in WAIT the captured one
    assign eval_cond = (state == IDLE) ? br_cond : cond_q;
    assign wr_dec    = PEND_W'(fs_wr);

    cond_eval u_eval (
        .flags (nxt_flags),
        .cond  (eval_cond),
        .taken (eval_taken)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cond_q   <= '0;
            taken_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            cond_q   <= cond_nxt;
            taken_q  <= taken_nxt;
        end
    end

    // Next state: branches resolve once every older flag-setter has written;
    // younger issues never enter wait_cnt
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        cond_nxt  = cond_q;
        taken_nxt = taken_q;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    cond_nxt = br_cond;
                    if (pend == '0 || (pend == PEND_ONE && fs_wr)) begin
                        taken_nxt = eval_taken;
                        state_nxt = RESP;
                    end else begin
                        wait_nxt  = pend - wr_dec;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (fs_wr) begin
                    if (wait_cnt == PEND_ONE) begin
                        taken_nxt = eval_taken;
                        wait_nxt  = '0;
                        state_nxt = RESP;
                    end else begin
                        wait_nxt = wait_cnt - PEND_ONE;
                    end
                end
            end
            RESP: begin
                if (br_resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            wait_nxt  = '0;
        end
    end

    assign br_ready      = (state == IDLE);
    assign br_resp_valid = (state == RESP);
    assign br_taken      = taken_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench: branch outcomes go through a scoreboard queue,
// flag/counter behaviour is checked inline per scenario.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n, flush, fs_issue, fs_wr;
    logic [3:0] fs_mask, br_cond;
    logic       c_in, s_in, v_in, z_in;
    logic       br_valid, br_ready, br_resp_valid, br_resp_ready, br_taken;
    logic       sv_save, sv_restore;
    logic [3:0] flags_q;
    logic       pend_full, ovf_err;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    flag_cond_unit #(.PEND_W(3), .RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fs_issue(fs_issue), .fs_wr(fs_wr), .fs_mask(fs_mask),
        .c_in(c_in), .s_in(s_in), .v_in(v_in), .z_in(z_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_resp_valid(br_resp_valid), .br_resp_ready(br_resp_ready),
        .br_taken(br_taken), .sv_save(sv_save), .sv_restore(sv_restore),
        .flags_q(flags_q), .pend_full(pend_full), .ovf_err(ovf_err)
    );

    // Reference condition table, {C,S,V,Z}
    function automatic logic model(input logic [3:0] f, input logic [3:0] cc);
        logic c, s, v, z;
        {c, s, v, z} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return s;
            4'h5: return !s;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return s == v;
            4'hB: return s != v;
            4'hC: return !z && (s == v);
            4'hD: return z || (s != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: compare each handshaken response against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && br_resp_valid && br_resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: br_taken=%0b with no expected response", br_taken);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if (br_taken !== e) begin
                    errors++;
                    $display("FAIL sb_taken: got %0b expected %0b", br_taken, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 0; fs_issue = 0; fs_wr = 0; fs_mask = 0;
        {c_in, s_in, v_in, z_in} = 4'b0000;
        br_valid = 0; br_cond = 0; sv_save = 0; sv_restore = 0;
        br_resp_ready = 1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic wr_flags(input logic [3:0] m, input logic [3:0] v);
        fs_wr = 1; fs_mask = m; {c_in, s_in, v_in, z_in} = v;
    endtask

    task automatic test_reset();
        clr();
        rst_n = 0;
        step(); step();
        chk("rst_flags", flags_q, 4'b0000);
        chk("rst_br_ready", {3'b0, br_ready}, 4'd1);
        chk("rst_resp_valid", {3'b0, br_resp_valid}, 4'd0);
        chk("rst_taken", {3'b0, br_taken}, 4'd0);
        chk("rst_ovf", {3'b0, ovf_err}, 4'd0);
        chk("rst_full", {3'b0, pend_full}, 4'd0);
        rst_n = 1;
        step();
    endtask

    task automatic test_always_never();
        for (int k = 0; k < 2; k++) begin
            br_valid = 1; br_cond = (k == 0) ? 4'hE : 4'hF;
            exp_q.push_back(k == 0);
            step();
            br_valid = 0;
            chk("aln_latency", {3'b0, br_resp_valid}, 4'd1);
            chk("aln_ready_resp", {3'b0, br_ready}, 4'd0);
            step();
            chk("aln_back_idle", {br_resp_valid, br_ready}, 4'b0001);
            chk("aln_flags", flags_q, 4'b0000);
        end
    endtask

    task automatic test_forward();
        fs_issue = 1; step(); fs_issue = 0;
        wr_flags(4'b1111, 4'b0100);
        br_valid = 1; br_cond = 4'hB;
        exp_q.push_back(1'b1);
        step(); clr();
        chk("fwd_resp", {3'b0, br_resp_valid}, 4'd1);
        chk("fwd_flags", flags_q, 4'b0100);
        step();
    endtask

    task automatic test_wait_order();
        fs_issue = 1; step(); step(); fs_issue = 0;
        br_valid = 1; br_cond = 4'h0;
        exp_q.push_back(1'b1);
        step(); br_valid = 0;
        chk("wt_ready", {br_ready, br_resp_valid}, 4'b0000);
        fs_issue = 1; step(); fs_issue = 0;
        chk("wt_young", {3'b0, br_resp_valid}, 4'd0);
        wr_flags(4'b1111, 4'b0000); step(); clr();
        chk("wt_first_wr", {3'b0, br_resp_valid}, 4'd0);
        wr_flags(4'b1111, 4'b0001); step(); clr();
        chk("wt_resolved", {3'b0, br_resp_valid}, 4'd1);
        chk("wt_flags", flags_q, 4'b0001);
        step();
        // One younger setter still pending: branch must wait for it
        br_valid = 1; br_cond = 4'hE; exp_q.push_back(1'b1);
        step(); br_valid = 0;
        chk("wt_pend1_wait", {br_ready, br_resp_valid}, 4'b0000);
        wr_flags(4'b0000, 4'b0000); step(); clr();
        chk("wt_pend1_done", {3'b0, br_resp_valid}, 4'd1);
        step();
        br_valid = 1; br_cond = 4'hE; exp_q.push_back(1'b1);
        step(); br_valid = 0;
        chk("wt_pend0", {3'b0, br_resp_valid}, 4'd1);
        step();
    endtask

    task automatic test_mask_shadow();
        wr_flags(4'b1111, 4'b1111); step(); clr();
        chk("msk_all", flags_q, 4'b1111);
        wr_flags(4'b0001, 4'b0000); step(); clr();
        chk("msk_z", flags_q, 4'b1110);
        sv_save = 1; step(); clr();
        wr_flags(4'b1111, 4'b0000); step(); clr();
        chk("sh_clobber", flags_q, 4'b0000);
        sv_restore = 1; step(); clr();
        chk("sh_restore", flags_q, 4'b1110);
        wr_flags(4'b1111, 4'b0011); step(); clr();
        sv_save = 1; sv_restore = 1; step(); clr();
        chk("sh_swap_flags", flags_q, 4'b1110);
        sv_restore = 1; wr_flags(4'b1111, 4'b1111); step(); clr();
        chk("sh_swap_shadow", flags_q, 4'b0011);
        wr_flags(4'b1111, 4'b0000); step(); clr();
        // Branch evaluated together with restore sees Z=1 from the shadow
        sv_restore = 1; br_valid = 1; br_cond = 4'h0;
        exp_q.push_back(1'b1);
        step(); clr();
        chk("sh_br_restore", {3'b0, br_resp_valid}, 4'd1);
        step();
    endtask

    task automatic test_cond_table();
        logic [3:0] pats [6];
        pats = '{4'b0000, 4'b1111, 4'b1010, 4'b0101, 4'b1001, 4'b0110};
        for (int p = 0; p < 6; p++) begin
            wr_flags(4'b1111, pats[p]); step(); clr();
            chk("tbl_flags", flags_q, pats[p]);
            for (int c = 0; c < 16; c++) begin
                br_valid = 1; br_cond = 4'(c);
                exp_q.push_back(model(pats[p], 4'(c)));
                step(); br_valid = 0;
                checks++;
                if (br_resp_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL tbl_resp: cond %0h got valid %b expected 1", c, br_resp_valid);
                end
                step();
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) begin
            chk("ovf_not_full", {3'b0, pend_full}, 4'd0);
            fs_issue = 1; step(); fs_issue = 0;
        end
        chk("ovf_full", {pend_full, ovf_err}, 4'b0010);
        fs_issue = 1; step(); fs_issue = 0;
        chk("ovf_set", {pend_full, ovf_err}, 4'b0011);
        fs_issue = 1; fs_wr = 1; step(); clr();
        chk("ovf_both", {3'b0, pend_full}, 4'd1);
        fs_wr = 1; step(); clr();
        chk("ovf_dec", {3'b0, pend_full}, 4'd0);
        flush = 1; step(); clr();
        chk("ovf_sticky", {3'b0, ovf_err}, 4'd1);
    endtask

    task automatic test_flush_hold();
        fs_issue = 1; step(); step(); step(); fs_issue = 0;
        br_valid = 1; br_cond = 4'hE;
        step(); br_valid = 0;
        chk("fl_waiting", {3'b0, br_ready}, 4'd0);
        flush = 1; wr_flags(4'b1111, 4'b1000); step(); clr();
        chk("fl_ready", {br_ready, br_resp_valid}, 4'b0010);
        chk("fl_flags", flags_q, 4'b1000);
        chk("fl_ovf_kept", {3'b0, ovf_err}, 4'd1);
        br_valid = 1; br_cond = 4'hE; exp_q.push_back(1'b1);
        step(); br_valid = 0;
        chk("fl_pend0", {3'b0, br_resp_valid}, 4'd1);
        step();
        br_resp_ready = 0;
        br_valid = 1; br_cond = 4'h2; exp_q.push_back(1'b1);
        step(); br_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_resp", {br_ready, br_resp_valid, 1'b0, br_taken}, 4'b0101);
            step();
        end
        br_resp_ready = 1;
        step();
        chk("hold_release", {br_resp_valid, br_ready}, 4'b0001);
    endtask

    task automatic test_async_reset();
        fs_issue = 1; step(); step(); fs_issue = 0;
        br_valid = 1; br_cond = 4'hE;
        step(); br_valid = 0;
        chk("ar_waiting", {3'b0, br_ready}, 4'd0);
        #2 rst_n = 0;
        #1;
        chk("ar_ready", {br_ready, br_resp_valid}, 4'b0010);
        chk("ar_flags", flags_q, 4'b0000);
        chk("ar_ovf", {pend_full, ovf_err}, 4'b0000);
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_always_never();
        test_forward();
        test_wait_order();
        test_mask_shadow();
        test_cond_table();
        test_overflow();
        test_flush_hold();
        test_async_reset();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer side of the ALU status path. Holds the architectural C/S/V/Z flag register, which is written from EX by flag-setting instructions.
- Tracks how many flag-setting instructions are in flight.
- Resolves conditional-branch requests from ID through a valid/ready handshake. Each branch resolves against exactly the flags its program-order predecessors produce.
- Provides an interrupt shadow copy of the flags, with save and restore.

Parameters:
- PEND_W, 3: width of the in-flight flag-setter counter. Maximum pending count is 2^PEND_W-1.
- RESET_FLAGS, 4'b0000: flag register value at reset, bit order {C,S,V,Z}.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- fs_issue  in  1  flag-setting instruction leaves ID this cycle
- fs_wr  in  1  flag-setting instruction writes flags in EX this cycle
- fs_mask  in  4  per-flag write enable, {C,S,V,Z}
- c_in, s_in, v_in, z_in  in  1 each  status from the ALU status detector
- br_valid  in  1  branch request
- br_ready  out  1  unit can accept a branch
- br_cond  in  4  condition code
- br_resp_valid  out  1  resolution available
- br_resp_ready  in  1  consumer takes the resolution
- br_taken  out  1  condition result, meaningful while br_resp_valid
- sv_save  in  1  copy flags to shadow
- sv_restore  in  1  load flags from shadow
- flags_q  out  4  architectural flags, {C,S,V,Z}
- pend_full  out  1  pending counter at maximum; ID must stall fs_issue
- ovf_err  out  1  sticky: fs_issue seen while full

Behaviour:

Reset:
- flags_q=RESET_FLAGS, shadow=RESET_FLAGS, pend=0, wait_cnt=0.
- FSM in IDLE; br_ready=1; br_resp_valid=0, br_taken=0, ovf_err=0.

Flag update:
- nxt_flags bit i = fs_wr&fs_mask[i] ? new_i : flags_q[i].
- sv_restore overrides: nxt_flags = shadow, and the same-cycle fs_wr is discarded.
- sv_save: shadow <= nxt_flags computed without restore. When save and restore coincide, flags and shadow swap.

Pending counter:
- +1 on fs_issue, -1 on fs_wr; both in the same cycle leaves it unchanged.
- fs_issue while pend==max is ignored and sets ovf_err.
- fs_wr while pend==0 still updates flags; the counter stays at 0.
- pend_full = (pend==max), combinational from pend.

Condition decode, bits of br_cond:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: S
- 5 PL: !S
- 6 VS: V
- 7 VC: !V
- 8 HI: C&!Z
- 9 LS: !C|Z
- A GE: S==V
- B LT: S!=V
- C GT: !Z&(S==V)
- D LE: Z|(S!=V)
- E AL: 1
- F NV: 0

Branch FSM (IDLE, WAIT, RESP):
- IDLE: br_ready=1. On br_valid, capture br_cond.
  - If pend==0, or pend==1 with fs_wr, evaluate on nxt_flags (forwarded) and go to RESP.
  - Otherwise wait_cnt <= pend - fs_wr and go to WAIT.
  - A same-cycle fs_issue is younger than the branch and is never counted in wait_cnt.
- WAIT: br_ready=0. wait_cnt decrements on fs_wr only; fs_issue does not affect it. When wait_cnt==1 and fs_wr, evaluate on nxt_flags and go to RESP.
- RESP: br_resp_valid=1, br_taken registered and stable. On br_resp_ready go to IDLE. br_ready stays 0 in RESP, so there is no back-to-back accept.
- Minimum latency: accepted in cycle N, br_resp_valid in N+1.
- flush (synchronous, highest priority over FSM and counter):
  - FSM -> IDLE; pend, wait_cnt -> 0; br_resp_valid -> 0.
  - flags_q, shadow and ovf_err are kept.
  - A same-cycle fs_wr still updates flags.
- A branch evaluated in the same cycle as sv_restore uses the restored flags.
- Asynchronous reset mid-WAIT or mid-RESP returns everything to the reset values immediately.

Decomposition:
- Package flag_cond_pkg:
  - flag bit indices C_B=3, S_B=2, V_B=1, Z_B=0
  - 4-bit condition-code constants COND_EQ..COND_NV
  - FSM state enum {IDLE, WAIT, RESP}
- One combinational sub-module cond_eval (flags[3:0], cond[3:0] -> taken), reusable by the decode stage.
- Counter, flags, shadow and FSM live in flag_cond_unit.

Test Plan:
1. Reset, then br_cond=E with pend=0 -> br_resp_valid next cycle, br_taken=1. Repeat with cond=F -> br_taken=0. flags_q=0000 throughout.
2. fs_wr with mask=1111 and C,S,V,Z=0,1,0,0, while a branch with cond=B is presented and pend=1 in the same cycle -> forwarding used, br_taken=1 (LT, S!=V). flags_q=0100 the next cycle.
3. Issue 2 setters, then branch cond=0 (EQ), then 1 younger fs_issue during WAIT. First fs_wr writes Z=0, second writes Z=1 -> resolves after the second write with br_taken=1; the younger issue is ignored. pend=1 afterwards.
4. Masked write: flags=1111, fs_wr mask=0001 with z_in=0 -> flags_q=1110. sv_save, then fs_wr all-zero mask=1111, then sv_restore -> flags_q=1110.
5. With PEND_W=3: 7 fs_issue -> pend_full=1. An 8th issue -> ovf_err=1, pend stays 7. fs_issue+fs_wr together -> pend stays 7.
6. Branch in WAIT with pend=3, then flush -> br_ready=1 next cycle, no br_resp_valid, pend=0. Also hold br_resp_ready=0 in RESP for 5 cycles -> br_taken stable and valid held.
